// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQ_NUM requesters.
// A grant is held for a burst that ends on src_last or on the 2**BURST_LOG beat cap.
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int REQ_NUM   = 4,
  parameter int REQ_LOG   = 2,
  parameter int BURST_LOG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_NUM-1:0]         src_valid,
  input  logic [REQ_NUM-1:0]         src_last,
  input  logic [REQ_NUM*WIDTH-1:0]   src_data,
  output logic [REQ_NUM-1:0]         src_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write_req,
  output logic [WIDTH-1:0]           fifo_write_data,
  output logic [REQ_LOG-1:0]         grant_id,
  output logic                       busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               r_state;
  logic [REQ_LOG-1:0]   r_grant_id;
  logic [REQ_LOG-1:0]   r_rr_ptr;
  logic [BURST_LOG-1:0] r_beat_cnt;

  logic                 w_hi_any, w_lo_any, w_any;
  logic [REQ_LOG-1:0]   w_hi_sel, w_lo_sel, w_sel;
  logic                 w_xfer, w_end;
  logic [REQ_LOG-1:0]   w_next_ptr;

  // Rotating priority split in two: lowest valid index at/after rr_ptr wins,
  // otherwise the lowest valid index below it (wrap-around).
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_sel = '0;
    w_lo_sel = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        if (REQ_LOG'(i) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_sel = REQ_LOG'(i);
        end else begin
          w_lo_any = 1'b1;
          w_lo_sel = REQ_LOG'(i);
        end
      end
    end
    w_any = w_hi_any | w_lo_any;
    w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
  end

  assign w_xfer     = (r_state == BURST) && src_valid[r_grant_id] && !fifo_full;
  assign w_end      = src_last[r_grant_id] || (r_beat_cnt == '1);
  assign w_next_ptr = (r_grant_id == REQ_LOG'(REQ_NUM - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    src_ready = '0;
    if (r_state == BURST && !fifo_full) src_ready[r_grant_id] = 1'b1;
  end

  assign fifo_write_req  = w_xfer;
  assign fifo_write_data = w_xfer ? src_data[int'(r_grant_id) * WIDTH +: WIDTH] : '0;
  assign grant_id        = r_grant_id;
  assign busy            = (r_state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id <= w_sel;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_end) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// compared against a burst-level reference model.
module tb_fifo_write_arbiter;

  localparam int WIDTH     = 8;
  localparam int REQ_NUM   = 4;
  localparam int REQ_LOG   = 2;
  localparam int BURST_LOG = 4;
  localparam int CAP       = 1 << BURST_LOG;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [REQ_NUM-1:0]       src_valid, src_last, src_ready;
  logic [REQ_NUM*WIDTH-1:0] src_data;
  logic                     fifo_full, fifo_write_req;
  logic [WIDTH-1:0]         fifo_write_data;
  logic [REQ_LOG-1:0]       grant_id;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of the port (-1 = none), beats moved, next start point.
  int m_owner, m_gid, m_ptr, m_beats;

  fifo_write_arbiter #(
    .WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .REQ_LOG(REQ_LOG), .BURST_LOG(BURST_LOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_last(src_last),
    .src_data(src_data), .src_ready(src_ready), .fifo_full(fifo_full),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_edge();
    bit found;
    bit xfer;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
        int c;
        c = (m_ptr + k) % REQ_NUM;
        if (!found && src_valid[c]) begin
          found = 1'b1; m_owner = c; m_gid = c; m_beats = 0;
        end
      end
    end else begin
      xfer = src_valid[m_owner] && !fifo_full;
      if (xfer) begin
        m_beats++;
        if (src_last[m_owner] || m_beats == CAP) begin
          m_ptr   = (m_owner + 1) % REQ_NUM;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    if (src_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b exp 0000", src_ready); end
    n_tests++;
    if (fifo_write_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", fifo_write_req); end
    n_tests++;
    if (fifo_write_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", fifo_write_data); end
    n_tests++;
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++;
    step(); step();
    rst_n = 1'b1;
    step(); #2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
    n_tests++;
  endtask

  task automatic test_single_burst();
    apply_reset();
    src_valid = 4'b0010; src_data[15:8] = 8'h11;
    #2;
    if (fifo_write_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sb_arb_cycle: got req=%b busy=%b exp 0 0", fifo_write_req, busy);
    end
    n_tests++;
    step(); #2;
    if (grant_id !== 2'd1) begin n_fail++; $display("FAIL sb_grant: got %0d exp 1", grant_id); end
    n_tests++;
    if (src_ready !== 4'b0010) begin n_fail++; $display("FAIL sb_ready: got %b exp 0010", src_ready); end
    n_tests++;
    if (fifo_write_req !== 1'b1 || fifo_write_data !== 8'h11) begin
      n_fail++; $display("FAIL sb_beat1: got req=%b data=%h exp 1 11", fifo_write_req, fifo_write_data);
    end
    n_tests++;
    step(); src_data[15:8] = 8'h12; #2;
    if (fifo_write_req !== 1'b1 || fifo_write_data !== 8'h12) begin
      n_fail++; $display("FAIL sb_beat2: got req=%b data=%h exp 1 12", fifo_write_req, fifo_write_data);
    end
    n_tests++;
    step(); src_data[15:8] = 8'h13; src_last = 4'b0010; #2;
    if (fifo_write_req !== 1'b1 || fifo_write_data !== 8'h13) begin
      n_fail++; $display("FAIL sb_beat3: got req=%b data=%h exp 1 13", fifo_write_req, fifo_write_data);
    end
    n_tests++;
    step(); src_valid = 4'b0111; src_last = 4'b0111; src_data[23:16] = 8'h22; #2;
    if (busy !== 1'b0 || fifo_write_req !== 1'b0 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL sb_after_idle: got busy=%b req=%b grant=%0d exp 0 0 1", busy, fifo_write_req, grant_id);
    end
    n_tests++;
    step(); #2;
    if (grant_id !== 2'd2 || fifo_write_data !== 8'h22) begin
      n_fail++; $display("FAIL sb_rr_ptr2: got grant=%0d data=%h exp 2 22", grant_id, fifo_write_data);
    end
    n_tests++;
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    apply_reset();
    src_valid = '1; src_last = '1;
    for (int i = 0; i < REQ_NUM; i++) src_data[i*WIDTH +: WIDTH] = 8'(8'hA0 + i);
    for (int c = 0; c < 10; c++) begin
      bit exp_w;
      int exp_g;
      #2;
      exp_w = (c % 2) == 1;
      exp_g = (c / 2) % REQ_NUM;
      if ($countones(src_ready) > 1) begin n_fail++; $display("FAIL rr_onehot c%0d: got %b exp <=1 bit", c, src_ready); end
      n_tests++;
      if (fifo_write_req !== exp_w || busy !== exp_w) begin
        n_fail++; $display("FAIL rr_req c%0d: got req=%b busy=%b exp %b", c, fifo_write_req, busy, exp_w);
      end
      n_tests++;
      if (exp_w) begin
        if (grant_id !== 2'(exp_g) || fifo_write_data !== 8'(8'hA0 + exp_g)) begin
          n_fail++; $display("FAIL rr_grant c%0d: got g=%0d d=%h exp g=%0d d=%h", c, grant_id, fifo_write_data, exp_g, 8'(8'hA0 + exp_g));
        end
        n_tests++;
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    int k;
    apply_reset();
    k = 0;
    src_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      bit exp_w, exp_b;
      fifo_full = (c >= 3 && c <= 5);
      src_data[23:16] = 8'(8'h20 + k);
      src_last = (k == 4) ? 4'b0100 : 4'b0000;
      #2;
      exp_w = (c >= 1 && c <= 2) || (c >= 6 && c <= 8);
      exp_b = (c >= 1 && c <= 8);
      if (fifo_write_req !== exp_w) begin n_fail++; $display("FAIL full_req c%0d: got %b exp %b", c, fifo_write_req, exp_w); end
      n_tests++;
      if (src_ready !== ((exp_b && !fifo_full) ? 4'b0100 : 4'b0000) || busy !== exp_b) begin
        n_fail++; $display("FAIL full_ready c%0d: got ready=%b busy=%b exp busy=%b", c, src_ready, busy, exp_b);
      end
      n_tests++;
      if (exp_w && (fifo_write_data !== 8'(8'h20 + k) || grant_id !== 2'd2)) begin
        n_fail++; $display("FAIL full_data c%0d: got %h g=%0d exp %h g=2", c, fifo_write_data, grant_id, 8'(8'h20 + k));
      end
      if (exp_w) n_tests++;
      step();
      if (exp_w) k++;
    end
    clear_inputs();
  endtask

  task automatic test_burst_cap();
    int  k0;
    bit  r3_pending;
    apply_reset();
    k0 = 0; r3_pending = 1'b1;
    for (int c = 0; c < 25; c++) begin
      int src;
      src_valid = {r3_pending, 2'b00, k0 < 20};
      src_last  = {1'b1, 2'b00, k0 == 19};
      src_data[7:0]   = 8'(8'h40 + k0);
      src_data[31:24] = 8'h3F;
      #2;
      if ((c >= 1 && c <= 16) || (c >= 20 && c <= 23)) src = 0;
      else if (c == 18) src = 3;
      else src = -1;
      if (fifo_write_req !== (src >= 0) || busy !== (src >= 0)) begin
        n_fail++; $display("FAIL cap_req c%0d: got req=%b busy=%b exp %b", c, fifo_write_req, busy, src >= 0);
      end
      n_tests++;
      if (src >= 0) begin
        if (grant_id !== 2'(src) || fifo_write_data !== ((src == 0) ? 8'(8'h40 + k0) : 8'h3F)) begin
          n_fail++; $display("FAIL cap_data c%0d: got g=%0d d=%h exp g=%0d", c, grant_id, fifo_write_data, src);
        end
        n_tests++;
      end
      step();
      if (src == 0) k0++;
      if (src == 3) r3_pending = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_valid_drop();
    apply_reset();
    src_valid = 4'b0010; src_data[15:8] = 8'h51; src_data[7:0] = 8'h05;
    step(); #2;
    if (fifo_write_req !== 1'b1 || grant_id !== 2'd1 || fifo_write_data !== 8'h51) begin
      n_fail++; $display("FAIL drop_first: got req=%b g=%0d d=%h exp 1 1 51", fifo_write_req, grant_id, fifo_write_data);
    end
    n_tests++;
    step(); src_valid = 4'b0001; src_last = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (fifo_write_req !== 1'b0 || grant_id !== 2'd1 || src_ready !== 4'b0010 || busy !== 1'b1) begin
        n_fail++; $display("FAIL drop_hold c%0d: got req=%b g=%0d ready=%b busy=%b exp 0 1 0010 1", c, fifo_write_req, grant_id, src_ready, busy);
      end
      n_tests++;
      step();
    end
    src_valid = 4'b0011; src_last = 4'b0011; src_data[15:8] = 8'h52; #2;
    if (fifo_write_req !== 1'b1 || fifo_write_data !== 8'h52) begin
      n_fail++; $display("FAIL drop_resume: got req=%b d=%h exp 1 52", fifo_write_req, fifo_write_data);
    end
    n_tests++;
    step(); src_valid = 4'b0001; #2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy=%b exp 0", busy); end
    n_tests++;
    step(); #2;
    if (grant_id !== 2'd0 || fifo_write_data !== 8'h05) begin
      n_fail++; $display("FAIL drop_next: got g=%0d d=%h exp 0 05", grant_id, fifo_write_data);
    end
    n_tests++;
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    src_valid = 4'b0010; src_last = 4'b0010; src_data[15:8] = 8'h71;
    step(); #2;
    if (fifo_write_data !== 8'h71) begin n_fail++; $display("FAIL rmb_pre: got %h exp 71", fifo_write_data); end
    n_tests++;
    step();
    src_valid = 4'b0100; src_last = 4'b0000; src_data[23:16] = 8'h61;
    step(); #2;
    if (fifo_write_data !== 8'h61 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL rmb_beat1: got d=%h g=%0d exp 61 2", fifo_write_data, grant_id);
    end
    n_tests++;
    step(); src_data[23:16] = 8'h62; #2;
    rst_n = 1'b0;
    #1;
    if (fifo_write_req !== 1'b0 || src_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0 || fifo_write_data !== 8'h00) begin
      n_fail++; $display("FAIL rmb_async: got req=%b ready=%b busy=%b g=%0d d=%h exp all 0", fifo_write_req, src_ready, busy, grant_id, fifo_write_data);
    end
    n_tests++;
    step(); step();
    rst_n = 1'b1;
    src_valid = 4'b1001; src_last = 4'b1001; src_data[7:0] = 8'h0A; src_data[31:24] = 8'h3A;
    #2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmb_idle: got busy=%b exp 0", busy); end
    n_tests++;
    step(); #2;
    if (grant_id !== 2'd0 || fifo_write_data !== 8'h0A) begin
      n_fail++; $display("FAIL rmb_ptr0: got g=%0d d=%h exp 0 0A", grant_id, fifo_write_data);
    end
    n_tests++;
    step();
    clear_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit                 e_busy, e_xfer;
      logic [REQ_NUM-1:0] e_ready;
      logic [WIDTH-1:0]   e_data;
      int                 last_odds;
      last_odds = (c < 300) ? 4 : 24;
      for (int i = 0; i < REQ_NUM; i++) begin
        src_valid[i] = ($urandom_range(0, 9) < 7);
        src_last[i]  = ($urandom_range(0, last_odds - 1) == 0);
      end
      src_data  = $urandom;
      fifo_full = ($urandom_range(0, 4) == 0);
      #2;
      e_busy  = (m_owner >= 0);
      e_ready = (e_busy && !fifo_full) ? REQ_NUM'(1 << m_owner) : '0;
      e_xfer  = e_busy && src_valid[(m_owner < 0) ? 0 : m_owner] && !fifo_full;
      e_data  = e_xfer ? src_data[m_owner*WIDTH +: WIDTH] : '0;
      if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b exp %b", c, busy, e_busy); end
      n_tests++;
      if (src_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, src_ready, e_ready); end
      n_tests++;
      if (fifo_write_req !== e_xfer) begin n_fail++; $display("FAIL rnd_req c%0d: got %b exp %b", c, fifo_write_req, e_xfer); end
      n_tests++;
      if (fifo_write_data !== e_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h exp %h", c, fifo_write_data, e_data); end
      n_tests++;
      if (grant_id !== 2'(m_gid)) begin n_fail++; $display("FAIL rnd_grant c%0d: got %0d exp %0d", c, grant_id, m_gid); end
      n_tests++;
      model_edge();
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fifo_full();
    test_burst_cap();
    test_valid_drop();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "bench timeout");
  end

endmodule
